// File: rtl/ysyx_22041461_divrem_seq.sv
// Radix-2 restoring divide/remainder unit (RV64M DIV/DIVU/REM/REMU and W variants).
// Define YSYX_22041461_DIVREM_FASTPATH_EN to resolve trivial cases without iterating.
module ysyx_22041461_divrem_seq #(
    parameter int XLEN   = 64,
    parameter int WORD_W = XLEN / 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  prem_q, quo_q, dvs_q, result_q;
    logic             isword_q, isrem_q, negq_q, negr_q, dz_q;
    logic             in_ready_q, out_valid_q;

    // Operand conditioning at accept time
    logic            is_signed, is_word, accept;
    logic [XLEN-1:0] a1, a2, abs1, abs2;
    logic            s1, s2, dz;

    always_comb begin
        is_signed = ~op_i[0];
        is_word   = op_i[1];
        if (is_word) begin
            a1 = is_signed ? {{(XLEN-WORD_W){src1_i[WORD_W-1]}}, src1_i[WORD_W-1:0]}
                           : {{(XLEN-WORD_W){1'b0}}, src1_i[WORD_W-1:0]};
            a2 = is_signed ? {{(XLEN-WORD_W){src2_i[WORD_W-1]}}, src2_i[WORD_W-1:0]}
                           : {{(XLEN-WORD_W){1'b0}}, src2_i[WORD_W-1:0]};
        end else begin
            a1 = src1_i;
            a2 = src2_i;
        end
        s1   = is_signed & a1[XLEN-1];
        s2   = is_signed & a2[XLEN-1];
        abs1 = s1 ? -a1 : a1;
        abs2 = s2 ? -a2 : a2;
        dz   = (a2 == '0);
    end

    assign accept = in_valid_i & in_ready_q & ~flush_i;

`ifdef YSYX_22041461_DIVREM_FASTPATH_EN
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};
    logic ovf, fast;
    always_comb begin
        ovf  = is_signed & (a2 == '1) & (a1 == (is_word ? MIN_W : MIN_X));
        fast = dz | ovf | (abs1 < abs2);
    end
`endif

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    logic [XLEN:0]   shifted, diff;
    logic            qbit;
    logic [XLEN-1:0] prem_d, quo_d;

    always_comb begin
        shifted = {prem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        qbit    = ~diff[XLEN];
        prem_d  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], qbit};
    end

    // Apply signs, divide-by-zero quotient, and W-result sign extension
    function automatic logic [XLEN-1:0] finish(
        input logic [XLEN-1:0] q, r,
        input logic nq, nr, dzf, word, remop
    );
        logic [XLEN-1:0] v;
        if (remop)    v = nr ? -r : r;
        else if (dzf) v = '1;
        else          v = nq ? -q : q;
        if (word) v = {{(XLEN-WORD_W){v[WORD_W-1]}}, v[WORD_W-1:0]};
        return v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            isword_q    <= 1'b0;
            isrem_q     <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i && state_q != IDLE) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    isword_q   <= is_word;
                    isrem_q    <= op_i[2];
                    negq_q     <= s1 ^ s2;
                    negr_q     <= s1;
                    dz_q       <= dz;
                    dvs_q      <= abs2;
                    prem_q     <= '0;
                    quo_q      <= is_word ? (abs1 << WORD_W) : abs1;
                    cnt_q      <= is_word ? CNT_W'(WORD_W) : CNT_W'(XLEN);
                    in_ready_q <= 1'b0;
                    state_q    <= CALC;
`ifdef YSYX_22041461_DIVREM_FASTPATH_EN
                    if (fast) begin
                        // Overflow yields |dividend| as magnitude; otherwise quotient is 0
                        result_q    <= finish(ovf ? abs1 : '0, ovf ? '0 : abs1,
                                              s1 ^ s2, s1, dz, is_word, op_i[2]);
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
`endif
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        result_q    <= finish(quo_q, prem_q, negq_q, negr_q, dz_q,
                                              isword_q, isrem_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        prem_q <= prem_d;
                        quo_q  <= quo_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
endmodule

// File: tb/tb_ysyx_22041461_divrem_seq.sv
// Directed, table-driven bench for ysyx_22041461_divrem_seq (64-bit default build).
module tb_ysyx_22041461_divrem_seq;
    localparam int XLEN = 64;
`ifdef YSYX_22041461_DIVREM_FASTPATH_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic            clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [2:0]      op = 0;
    logic [XLEN-1:0] src1 = 0, src2 = 0;
    logic            in_ready, out_valid;
    logic [XLEN-1:0] result;

    ysyx_22041461_divrem_seq #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
        .src1_i(src1), .src2_i(src2),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    localparam logic [2:0] DIV = 3'b000, DIVU = 3'b001, DIVW = 3'b010, DIVUW = 3'b011,
                           REM = 3'b100, REMU = 3'b101, REMW = 3'b110, REMUW = 3'b111;

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a, b, exp;
        bit              fast;
    } vec_t;

    // Drive a request at the negedge and return after the accepting edge
    task automatic start_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        op = o; src1 = a; src2 = b; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    // Count edges after accept until out_valid seen (bounded)
    task automatic wait_done(output int k);
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("post_consume_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_consume_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit fast);
        int k, lat;
        lat = (FAST_EN && fast) ? 1 : ((o[1] ? 32 : 64) + 1);
        start_op(o, a, b);
        wait_done(k);
        chk({name, "_latency"}, XLEN'(k), XLEN'(lat));
        chk({name, "_result"}, result, exp);
        consume();
    endtask

    initial begin
        vec_t vt[18];
        int k;
        bit seen;
        vt[0]  = '{REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1]  = '{REMUW, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_0000_0003, 64'd2, 1'b0};
        vt[2]  = '{DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vt[3]  = '{REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1};
        vt[4]  = '{DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[5]  = '{REMU,  64'd100, 64'd0, 64'd100, 1'b1};
        vt[6]  = '{DIV,   64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vt[7]  = '{DIV,   64'd100, 64'd7, 64'd14, 1'b0};
        vt[8]  = '{DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
        vt[9]  = '{REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vt[10] = '{DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        vt[11] = '{DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vt[12] = '{REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vt[13] = '{DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vt[14] = '{DIV,   64'd3, 64'd10, 64'd0, 1'b1};
        vt[15] = '{REMW,  64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[16] = '{DIVW,  64'h0000_0000_0000_000A, 64'hAAAA_AAAA_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vt[17] = '{REMU,  64'd0, 64'd5, 64'd0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 0;

        foreach (vt[i]) run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].fast);

        // Back-pressure: result held while out_ready stays low
        start_op(DIV, 64'd100, 64'd7);
        wait_done(k);
        chk("bp_latency", XLEN'(k), 64'd65);
        repeat (10) @(negedge clk);
        chk("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
        chk("bp_result_held", result, 64'd14);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        consume();

        // Flush in CALC at cycle 20: result never appears
        start_op(DIVU, 64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        @(negedge clk) flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush_no_result", {63'd0, seen}, 64'd0);
        run_op("after_flush", DIV, 64'd100, 64'd7, 64'd14, 1'b0);

        // Flush in IDLE alongside in_valid: request is not accepted
        @(negedge clk);
        op = DIV; src1 = 64'd50; src2 = 64'd5; in_valid = 1; flush = 1;
        @(posedge clk);
        #1 in_valid = 0; flush = 0;
        @(negedge clk);
        chk("idle_flush_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("idle_flush_not_accepted", {63'd0, seen}, 64'd0);

        // Reset mid-CALC
        start_op(DIV, 64'd12345, 64'd17);
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_result", result, 64'd0);
        run_op("after_rst", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
